demux16_stream: RTL and testbench
=================================

Name: demux16_stream

Overview:
- 1-to-2 demultiplexing stream router: steers each beat of a 16-bit valid/ready input stream to output channel A (in_sel=0) or channel B (in_sel=1).
- Packet-aware: the destination chosen on a packet's first beat is locked until the beat carrying in_last.
- Each output channel has a one-entry registered slot. Sits on the write side of datapath muxes, fanning a single producer out to two consumers.

Parameters:
WIDTH, 16, data width of input and both output channels

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  WIDTH  input beat payload
in_sel  input  1  destination select for first beat of packet (0 = A, 1 = B)
in_last  input  1  marks final beat of packet
in_valid  input  1  input beat present
in_ready  output  1  router accepts beat this cycle
out_a_data  output  WIDTH  channel A payload
out_a_last  output  1  channel A last flag
out_a_valid  output  1  channel A slot full
out_a_ready  input  1  channel A consumer accepts
out_b_data  output  WIDTH  channel B payload
out_b_last  output  1  channel B last flag
out_b_valid  output  1  channel B slot full
out_b_ready  input  1  channel B consumer accepts

Behaviour:
- Reset (rst=1, async): state=IDLE; out_a_valid=out_b_valid=0; out_*_data=0; out_*_last=0.
- States:
  - IDLE: destination = in_sel.
  - LOCK_A: destination = A, in_sel ignored.
  - LOCK_B: destination = B, in_sel ignored.
- Transfer: in_valid && in_ready, where in_ready = !dest_valid || dest_ready for the current destination. in_ready is combinational from out_x_ready/out_x_valid/state/in_sel; it does not depend on in_valid.
- Transitions:
  - IDLE, transfer with in_last=0: go to LOCK_dest.
  - IDLE, transfer with in_last=1 (single-beat packet): stay in IDLE.
  - LOCK_x, transfer with in_last=1: go to IDLE.
  - Otherwise hold state.
- Output slot X, per cycle:
  - Transfer routed to X: load data/last, valid=1. This takes priority over the drain, so a simultaneous drain and refill gives full throughput.
  - Else if out_x_valid && out_x_ready: valid=0; data/last hold their last value.
  - Else hold.
- Data appears at the selected output 1 cycle after the accepting edge. Sustained 1 beat/cycle when the destination ready is held high.
- The non-selected channel is never modified. Its pending beat may drain independently while the other channel is loaded.
- in_sel changes mid-packet have no effect. A change while in IDLE with in_valid=1 and in_ready=0 retargets the beat; no beat is lost or duplicated.
- Destination slot full and not draining: in_ready=0, state and slots hold.
- rst asserted mid-packet: slots are emptied immediately and pending beats discarded; the next accepted beat is treated as a first beat.
- Data/last never change while the corresponding valid=1 and ready=0.

Optional Feature:
- Macro DEMUX16_STREAM_COUNT_EN.
- Defined:
  - Adds outputs count_a and count_b (16 bits each) and input count_clr (1 bit).
  - Each counter increments on every beat accepted into its channel and saturates at 16'hFFFF.
  - count_clr=1 zeroes both counters synchronously, taking priority over an increment the same cycle.
  - rst zeroes both counters.
- Not defined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-simulation with out_a_valid=1 -> out_a_valid=0, out_b_valid=0 and data=16'h0000 immediately (before the next clk edge); state IDLE.
- Single-beat routing: in_sel=1, in_last=1, in_data=16'hBEEF, out_b_ready=1 -> next cycle out_b_valid=1, out_b_data=16'hBEEF, out_b_last=1; out_a_valid stays 0.
- Packet lock: 3-beat packet 16'h0001/0002/0003, in_sel=0 on beat 1 and toggled to 1 on beats 2-3 -> all three beats appear on A in order, last=1 on 16'h0003; B untouched.
- Backpressure: out_a_ready=0 with A full, in_sel=0, in_valid=1 -> in_ready=0, out_a_data stable. Raise out_a_ready -> one beat accepted on that edge, no loss or duplication.
- Throughput: 8 back-to-back single-beat packets alternating sel 0/1, both readies=1 -> in_ready=1 every cycle; A gets beats 0,2,4,6 and B gets 1,3,5,7.
- With DEMUX16_STREAM_COUNT_EN: 5 beats to A, 2 to B -> count_a=5, count_b=2. Pulse count_clr during a beat to A -> both counters 0 the next cycle.

Source files
------------

// File: rtl/demux16_stream.sv
// demux16_stream: packet-aware 1-to-2 valid/ready stream router.
// A packet's first beat picks channel A (in_sel=0) or B (in_sel=1);
// the choice is locked until the beat carrying in_last.
// Each output channel is a one-entry registered slot.
//
// Ports:
//   clk, rst               clock, async active-high reset
//   in_data/sel/last       input beat payload, destination, end-of-packet
//   in_valid, in_ready     input handshake
//   out_a_data/last/valid  channel A slot, out_a_ready from consumer A
//   out_b_data/last/valid  channel B slot, out_b_ready from consumer B
// Optional (DEMUX16_STREAM_COUNT_EN defined):
//   count_clr              sync clear of both beat counters
//   count_a, count_b       saturating per-channel accepted-beat counts
module demux16_stream #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a_data,
    output logic             out_a_last,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    output logic [WIDTH-1:0] out_b_data,
    output logic             out_b_last,
    output logic             out_b_valid,
    input  logic             out_b_ready
`ifdef DEMUX16_STREAM_COUNT_EN
    ,
    input  logic             count_clr,
    output logic [15:0]      count_a,
    output logic [15:0]      count_b
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   dest_b;
    logic   xfer;
    logic   load_a;
    logic   load_b;

    always_comb begin
        state_nxt = state;
        dest_b    = in_sel;
        in_ready  = 1'b0;
        xfer      = 1'b0;
        load_a    = 1'b0;
        load_b    = 1'b0;

        unique case (state)
            IDLE:    dest_b = in_sel;
            LOCK_A:  dest_b = 1'b0;
            LOCK_B:  dest_b = 1'b1;
            default: dest_b = in_sel;
        endcase

        // Independent of in_valid so the producer may wait on it.
        if (dest_b)
            in_ready = !out_b_valid || out_b_ready;
        else
            in_ready = !out_a_valid || out_a_ready;

        xfer   = in_valid && in_ready;
        load_a = xfer && !dest_b;
        load_b = xfer && dest_b;

        if (xfer) begin
            if (in_last)
                state_nxt = IDLE;
            else if (state == IDLE)
                state_nxt = dest_b ? LOCK_B : LOCK_A;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_a_valid <= 1'b0;
            out_a_data  <= '0;
            out_a_last  <= 1'b0;
            out_b_valid <= 1'b0;
            out_b_data  <= '0;
            out_b_last  <= 1'b0;
        end else begin
            state <= state_nxt;

            // A refill wins over a drain: full rate with ready held high.
            if (load_a) begin
                out_a_valid <= 1'b1;
                out_a_data  <= in_data;
                out_a_last  <= in_last;
            end else if (out_a_valid && out_a_ready) begin
                out_a_valid <= 1'b0;
            end

            if (load_b) begin
                out_b_valid <= 1'b1;
                out_b_data  <= in_data;
                out_b_last  <= in_last;
            end else if (out_b_valid && out_b_ready) begin
                out_b_valid <= 1'b0;
            end
        end
    end

`ifdef DEMUX16_STREAM_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_a <= '0;
            count_b <= '0;
        end else if (count_clr) begin
            count_a <= '0;
            count_b <= '0;
        end else begin
            if (load_a && count_a != 16'hFFFF)
                count_a <= count_a + 16'd1;
            if (load_b && count_b != 16'hFFFF)
                count_b <= count_b + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux16_stream.sv
// tb_demux16_stream: directed plus random stimulus for demux16_stream,
// checked against a packet-level reference model and beat scoreboards.
module tb_demux16_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_a_data;
    logic        out_a_last;
    logic        out_a_valid;
    logic        out_a_ready;
    logic [15:0] out_b_data;
    logic        out_b_last;
    logic        out_b_valid;
    logic        out_b_ready;
`ifdef DEMUX16_STREAM_COUNT_EN
    logic        count_clr;
    logic [15:0] count_a;
    logic [15:0] count_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    demux16_stream #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_last     (in_last),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_a_data  (out_a_data),
        .out_a_last  (out_a_last),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_b_data  (out_b_data),
        .out_b_last  (out_b_last),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready)
`ifdef DEMUX16_STREAM_COUNT_EN
        ,
        .count_clr   (count_clr),
        .count_a     (count_a),
        .count_b     (count_b)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: per-channel slot contents, packet lock,
    // and a queue of beats each consumer is owed, in order.
    logic        m_v [2];
    logic [15:0] m_d [2];
    logic        m_l [2];
    bit          m_busy;
    int          m_dest;
    int          m_cnt [2];
    logic [16:0] owed [2][$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_v[c]   = 1'b0;
            m_d[c]   = 16'h0;
            m_l[c]   = 1'b0;
            m_cnt[c] = 0;
            owed[c].delete();
        end
        m_busy = 0;
        m_dest = 0;
    endtask

    function automatic int m_target();
        return m_busy ? m_dest : int'(in_sel);
    endfunction

    function automatic logic m_ready();
        logic r [2];
        int   d;
        r[0] = out_a_ready;
        r[1] = out_b_ready;
        d = m_target();
        return !m_v[d] || r[d];
    endfunction

    // Consumer side: any beat leaving the DUT must be the next owed one.
    task automatic consume(input int c, input logic v, input logic r,
                           input logic [15:0] d, input logic l);
        logic [16:0] exp;
        if (v && r) begin
            if (owed[c].size() == 0) begin
                chk($sformatf("extra_beat_%0d", c), {l, d}, 17'h1FFFF);
            end else begin
                exp = owed[c].pop_front();
                chk($sformatf("beat_order_%0d", c), {l, d}, exp);
            end
        end
    endtask

    // One clock: check in_ready, advance model, check registered outputs.
    task automatic cyc();
        logic r [2];
        int   d;
        logic x;
        #1;
        chk("in_ready", in_ready, m_ready());
        r[0] = out_a_ready;
        r[1] = out_b_ready;
        d = m_target();
        x = in_valid && m_ready();
        consume(0, out_a_valid, out_a_ready, out_a_data, out_a_last);
        consume(1, out_b_valid, out_b_ready, out_b_data, out_b_last);
        for (int c = 0; c < 2; c++) begin
            if (x && d == c) begin
                m_v[c] = 1'b1;
                m_d[c] = in_data;
                m_l[c] = in_last;
                owed[c].push_back({in_last, in_data});
            end else if (m_v[c] && r[c]) begin
                m_v[c] = 1'b0;
            end
        end
`ifdef DEMUX16_STREAM_COUNT_EN
        for (int c = 0; c < 2; c++) begin
            if (count_clr)
                m_cnt[c] = 0;
            else if (x && d == c && m_cnt[c] < 65535)
                m_cnt[c]++;
        end
`endif
        if (x) begin
            if (in_last) begin
                m_busy = 0;
            end else if (!m_busy) begin
                m_busy = 1;
                m_dest = d;
            end
        end
        @(posedge clk);
        #1;
        chk("a_valid", out_a_valid, m_v[0]);
        chk("b_valid", out_b_valid, m_v[1]);
        chk("a_data", out_a_data, m_d[0]);
        chk("b_data", out_b_data, m_d[1]);
        chk("a_last", out_a_last, m_l[0]);
        chk("b_last", out_b_last, m_l[1]);
`ifdef DEMUX16_STREAM_COUNT_EN
        chk("count_a", count_a, m_cnt[0]);
        chk("count_b", count_b, m_cnt[1]);
`endif
    endtask

    task automatic drive(input logic v, input logic s, input logic l,
                         input logic [15:0] d);
        in_valid = v;
        in_sel   = s;
        in_last  = l;
        in_data  = d;
    endtask

    initial begin
        rst         = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        out_a_ready = 1'b0;
        out_b_ready = 1'b0;
`ifdef DEMUX16_STREAM_COUNT_EN
        count_clr   = 1'b0;
`endif
        model_reset();

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_a_valid", out_a_valid, 1'b0);
        chk("rst_b_valid", out_b_valid, 1'b0);
        chk("rst_a_data", out_a_data, 16'h0);
        chk("rst_b_last", out_b_last, 1'b0);
        rst = 1'b0;

        // Single-beat packet to B
        out_b_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 16'hBEEF);
        cyc();
        chk("single_b_valid", out_b_valid, 1'b1);
        chk("single_b_data", out_b_data, 16'hBEEF);
        chk("single_b_last", out_b_last, 1'b1);
        chk("single_a_valid", out_a_valid, 1'b0);

        // Packet lock: sel flips mid-packet, beats stay on A
        out_a_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'h0001);
        cyc();
        chk("lock_beat1", out_a_data, 16'h0001);
        drive(1'b1, 1'b1, 1'b0, 16'h0002);
        cyc();
        chk("lock_beat2", out_a_data, 16'h0002);
        chk("lock_b_idle", out_b_valid, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 16'h0003);
        cyc();
        chk("lock_beat3", {out_a_last, out_a_data}, 17'h10003);
        chk("lock_b_idle2", out_b_valid, 1'b0);

        // Backpressure on a full A slot
        out_a_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 16'h00AA);
        #1;
        chk("bp_in_ready", in_ready, 1'b0);
        cyc();
        cyc();
        chk("bp_hold_data", out_a_data, 16'h0003);
        out_a_ready = 1'b1;
        cyc();
        chk("bp_release", out_a_data, 16'h00AA);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        cyc();
        chk("bp_drained", out_a_valid, 1'b0);

        // Throughput: alternate channels, one beat per cycle
        out_b_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'(i % 2), 1'b1, 16'(i));
            #1;
            chk("tp_in_ready", in_ready, 1'b1);
            cyc();
            if (i % 2 == 0)
                chk("tp_a_data", out_a_data, 16'(i));
            else
                chk("tp_b_data", out_b_data, 16'(i));
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        cyc();

`ifdef DEMUX16_STREAM_COUNT_EN
        count_clr = 1'b1;
        cyc();
        count_clr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'(i >= 5), 1'b1, 16'h100 + 16'(i));
            cyc();
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        cyc();
        chk("cnt_a5", count_a, 16'd5);
        chk("cnt_b2", count_b, 16'd2);
        count_clr = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 16'h0777);
        cyc();
        count_clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        chk("cnt_clr_a", count_a, 16'd0);
        chk("cnt_clr_b", count_b, 16'd0);
        cyc();
`endif

        // Async reset mid-packet with A holding a beat
        out_a_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 16'h5A5A);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 16'h1111);
        out_b_ready = 1'b1;
        cyc();
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        chk("pre_rst_a_valid", out_a_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_a_valid", out_a_valid, 1'b0);
        chk("arst_b_valid", out_b_valid, 1'b0);
        chk("arst_a_data", out_a_data, 16'h0);
        chk("arst_b_data", out_b_data, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        // After reset the next beat is a first beat again
        out_a_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 16'h2222);
        cyc();
        chk("post_rst_a", {out_a_valid, out_a_data}, 17'h12222);
        chk("post_rst_b", out_b_valid, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom),
                  1'($urandom_range(0, 2) == 0), 16'($urandom));
            out_a_ready = 1'($urandom_range(0, 3) != 0);
            out_b_ready = 1'($urandom_range(0, 3) != 0);
`ifdef DEMUX16_STREAM_COUNT_EN
            count_clr = 1'($urandom_range(0, 40) == 0);
`endif
            cyc();
        end

        // Drain and confirm nothing was lost
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        out_a_ready = 1'b1;
        out_b_ready = 1'b1;
`ifdef DEMUX16_STREAM_COUNT_EN
        count_clr = 1'b0;
`endif
        for (int i = 0; i < 3; i++)
            cyc();
        chk("owed_a_empty", owed[0].size(), 0);
        chk("owed_b_empty", owed[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
